leaf_router_port_gen: RTL and testbench
=======================================

Name: leaf_router_port_gen

Overview:
Parametrised leaf-router port between one GPU network interface and NUM_SPINES spine links. It generalises the fixed 4-spine, 16-bit, always-ready leaf router: spine count, width, FIFO depth and group ID are parameters. It adds full valid/ready backpressure on every link, round-robin arbitration toward the GPU, and same-group loopback. It sits between the NI and the spine fabric inside each GPU tile.

Parameters:
DWIDTH, 16, flit width; destination field is flit[DWIDTH-1 -: DEST_W].
DEST_W, 6, destination field width.
GROUP_W, 4, group field width = top GROUP_W bits of the destination field.
GROUP_ID, 4'd1, this router's group.
NUM_SPINES, 4, spine link count; power of 2, 2..8.
FIFO_DEPTH, 4, entries per input FIFO; power of 2, >= 2.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous active-high reset.
arb_enable  in  1  when 0, no new grants toward the GPU.
gpu_in_data  in  DWIDTH  flit from NI.
gpu_in_valid  in  1  NI flit valid.
gpu_in_ready  out  1  GPU input FIFO not full.
gpu_out_data  out  DWIDTH  flit to NI.
gpu_out_valid  out  1  flit to NI valid.
gpu_out_ready  in  1  NI accepts.
spine_in_data  in  NUM_SPINES*DWIDTH  spine i occupies bits [i*DWIDTH +: DWIDTH].
spine_in_valid  in  NUM_SPINES  per-spine valid.
spine_in_ready  out  NUM_SPINES  per-spine input FIFO not full.
spine_out_data  out  NUM_SPINES*DWIDTH  flits to spines, same packing.
spine_out_valid  out  NUM_SPINES  per-spine valid.
spine_out_ready  in  NUM_SPINES  per-spine accept.
current_grant  out  $clog2(NUM_SPINES+1)  last granted requester; index NUM_SPINES = loopback.
crossbar_busy  out  1  any FIFO non-empty or any output register valid.

Behaviour:
- Transfer rule: a flit moves on a rising edge when valid && ready. Valid, once raised, holds with stable data until accepted.
- Reset: asynchronous. All FIFOs empty. All *_out_valid = 0. Loopback register empty. RR pointer = 0. current_grant = 0. crossbar_busy = 0. gpu_in_ready and spine_in_ready go to 1 while reset is high. Reset asserted mid-transfer discards all in-flight flits.
- FIFOs: ready = !full. Push and pop in the same cycle are legal when not empty; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH. There is no pass-through when full.
- Upstream decode (GPU FIFO head): grp = flit[DWIDTH-1 -: GROUP_W].
  - grp == GROUP_ID: target is the one-entry loopback register.
  - Otherwise: target spine = flit[DWIDTH-DEST_W +: $clog2(NUM_SPINES)].
- Upstream pop: the head pops when its target register is empty, or is being accepted in the same cycle (back-to-back throughput of 1 flit/cycle). A blocked head stalls the GPU FIFO; there is no bypass, so order is preserved.
- Downstream arbitration: requesters are NUM_SPINES spine FIFOs plus the loopback register (index NUM_SPINES).
  - Grant when arb_enable=1 and (gpu_out_valid=0 or gpu_out_ready=1).
  - Round-robin search starts at the RR pointer. The winner is popped into the gpu_out register and the pointer becomes winner+1 mod (NUM_SPINES+1).
  - current_grant updates on a grant and holds otherwise.
  - arb_enable=0 does not drop a pending gpu_out_valid.
- Latency: a flit accepted on edge k is visible at its output after edge k+2 when there is no contention, both upstream and downstream. Loopback takes 3 edges.
- Per-source FIFO order is preserved. There is no ordering guarantee across sources.
- crossbar_busy is combinational from FIFO and register state.

Test Plan:
- Reset while gpu_in_valid=1 -> all *_out_valid=0, gpu_in_ready=1, current_grant=0. After release, the first GPU flit is accepted next edge.
- GPU sends 16'h2C55 with all spine_out_ready=1 -> spine_out_valid=4'b1000 and spine_out_data[63:48]=16'h2C55 two edges after acceptance. Other spines stay idle.
- GPU sends 16'h1455 (group 1 = GROUP_ID) -> no spine_out_valid. gpu_out_data=16'h1455 with gpu_out_valid=1 three edges later, current_grant=4.
- Spines 0..3 each push one flit (16'h0A00..16'h0A03) on the same edge, gpu_out_ready=1 -> gpu_out delivers 0A00, 0A01, 0A02, 0A03 on consecutive cycles. current_grant steps 0,1,2,3.
- spine_out_ready[1]=0, GPU sends 6 flits to spine 1 (e.g. 16'h2400) -> one is held in the output register and 4 fill the FIFO. gpu_in_ready drops to 0 with the 6th flit still pending. Releasing ready drains all 6 in order.
- arb_enable=0 with spine 2 FIFO holding 2 flits -> gpu_out_valid stays 0 and spine_in_ready[2]=1 until full. Setting arb_enable=1 delivers both flits in order.

Source files
------------

// File: rtl/leaf_router_port_gen.sv
// Leaf-router port joining one GPU network interface to NUM_SPINES spine links, with group loopback.
// Latency: 2 edges from input acceptance to any output register; loopback flits take 3.
// Backpressure: valid/ready on every link; a blocked GPU-FIFO head stalls that FIFO; inputs see ready = !full.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   arb_enable                      gates new grants toward the GPU
//   gpu_in_*  / gpu_out_*           flits from / to the network interface
//   spine_in_* / spine_out_*        per-spine flits, spine i in bits [i*DWIDTH +: DWIDTH]
//   current_grant                   last granted requester (NUM_SPINES = loopback)
//   crossbar_busy                   any FIFO or output register occupied

// Generic synchronous FIFO. A written entry becomes poppable one edge after
// the write (the read side follows a delayed copy of the write pointer), while
// fullness tracks the real write pointer, so capacity is exactly DEPTH.
module leaf_router_port_gen_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    output logic             push_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    input  logic             pop,
    output logic             occupied
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      vis_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign head_valid = (vis_ptr != rd_ptr);
    assign do_pop     = pop && head_valid;
    assign head_data  = mem[rd_ptr[AW-1:0]];
    assign occupied   = (wr_ptr != rd_ptr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            vis_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            vis_ptr <= wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module leaf_router_port_gen #(
    parameter int                 DWIDTH     = 16,
    parameter int                 DEST_W     = 6,
    parameter int                 GROUP_W    = 4,
    parameter logic [GROUP_W-1:0] GROUP_ID   = 4'd1,
    parameter int                 NUM_SPINES = 4,
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             arb_enable,
    input  logic [DWIDTH-1:0]                gpu_in_data,
    input  logic                             gpu_in_valid,
    output logic                             gpu_in_ready,
    output logic [DWIDTH-1:0]                gpu_out_data,
    output logic                             gpu_out_valid,
    input  logic                             gpu_out_ready,
    input  logic [NUM_SPINES*DWIDTH-1:0]     spine_in_data,
    input  logic [NUM_SPINES-1:0]            spine_in_valid,
    output logic [NUM_SPINES-1:0]            spine_in_ready,
    output logic [NUM_SPINES*DWIDTH-1:0]     spine_out_data,
    output logic [NUM_SPINES-1:0]            spine_out_valid,
    input  logic [NUM_SPINES-1:0]            spine_out_ready,
    output logic [$clog2(NUM_SPINES+1)-1:0]  current_grant,
    output logic                             crossbar_busy
);
    localparam int SW = $clog2(NUM_SPINES);
    localparam int GW = $clog2(NUM_SPINES+1);

    // GPU input FIFO
    logic [DWIDTH-1:0] gpu_head;
    logic              gpu_head_valid;
    logic              gpu_pop;
    logic              gpu_occ;

    // Spine input FIFOs
    logic [DWIDTH-1:0]     sp_head [NUM_SPINES];
    logic [NUM_SPINES-1:0] sp_head_valid;
    logic [NUM_SPINES-1:0] sp_pop;
    logic [NUM_SPINES-1:0] sp_occ;

    // Loopback register and arbitration state
    logic [DWIDTH-1:0]   lb_data;
    logic                lb_valid;
    logic [GW-1:0]       rr_ptr;
    logic [NUM_SPINES:0] req;
    logic                arb_open;
    logic                win_found;
    logic [GW-1:0]       win_idx;
    logic [GW-1:0]       cand_idx;
    int                  cand;
    logic [DWIDTH-1:0]   win_data;
    logic                grant;
    logic                lb_drain;

    // Upstream decode
    logic                  head_loop;
    logic [SW-1:0]         head_spine;
    logic [NUM_SPINES-1:0] sp_free;

    leaf_router_port_gen_fifo #(.WIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_gpu_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_data  (gpu_in_data),
        .push_valid (gpu_in_valid),
        .push_ready (gpu_in_ready),
        .head_data  (gpu_head),
        .head_valid (gpu_head_valid),
        .pop        (gpu_pop),
        .occupied   (gpu_occ)
    );

    for (genvar g = 0; g < NUM_SPINES; g++) begin : g_spine
        leaf_router_port_gen_fifo #(.WIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_spine_fifo (
            .clk        (clk),
            .reset      (reset),
            .push_data  (spine_in_data[g*DWIDTH +: DWIDTH]),
            .push_valid (spine_in_valid[g]),
            .push_ready (spine_in_ready[g]),
            .head_data  (sp_head[g]),
            .head_valid (sp_head_valid[g]),
            .pop        (sp_pop[g]),
            .occupied   (sp_occ[g])
        );
        assign sp_pop[g] = grant && (win_idx == GW'(g));
    end

    // ---------------- Downstream arbitration toward the GPU ----------------
    assign req      = {lb_valid, sp_head_valid};
    assign arb_open = arb_enable && (!gpu_out_valid || gpu_out_ready);
    assign grant    = arb_open && win_found;
    assign lb_drain = grant && (win_idx == GW'(NUM_SPINES));

    // Round-robin: first requester at or after rr_ptr, wrapping over NUM_SPINES+1 slots.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k <= NUM_SPINES; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand > NUM_SPINES) cand = cand - (NUM_SPINES + 1);
            cand_idx = GW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_data = lb_data;
        for (int i = 0; i < NUM_SPINES; i++) begin
            if (win_idx == GW'(i)) win_data = sp_head[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpu_out_valid <= 1'b0;
            gpu_out_data  <= '0;
            current_grant <= '0;
            rr_ptr        <= '0;
        end else if (grant) begin
            gpu_out_valid <= 1'b1;
            gpu_out_data  <= win_data;
            current_grant <= win_idx;
            rr_ptr        <= (win_idx == GW'(NUM_SPINES)) ? '0 : win_idx + 1'b1;
        end else if (gpu_out_ready) begin
            // Accepted (or already empty) with nothing new granted.
            gpu_out_valid <= 1'b0;
        end
    end

    // ---------------- Upstream routing from the GPU FIFO ----------------
    assign head_loop  = (gpu_head[DWIDTH-1 -: GROUP_W] == GROUP_ID);
    assign head_spine = gpu_head[DWIDTH-DEST_W +: SW];
    assign sp_free    = ~spine_out_valid | spine_out_ready;

    // Head leaves only when its own target can take it; no bypass keeps order.
    assign gpu_pop = gpu_head_valid &&
                     (head_loop ? (!lb_valid || lb_drain) : sp_free[head_spine]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spine_out_valid <= '0;
            spine_out_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_SPINES; i++) begin
                if (gpu_pop && !head_loop && (head_spine == SW'(i))) begin
                    spine_out_valid[i]               <= 1'b1;
                    spine_out_data[i*DWIDTH +: DWIDTH] <= gpu_head;
                end else if (spine_out_ready[i]) begin
                    spine_out_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lb_valid <= 1'b0;
            lb_data  <= '0;
        end else if (gpu_pop && head_loop) begin
            lb_valid <= 1'b1;
            lb_data  <= gpu_head;
        end else if (lb_drain) begin
            lb_valid <= 1'b0;
        end
    end

    assign crossbar_busy = gpu_occ || (|sp_occ) || lb_valid || gpu_out_valid || (|spine_out_valid);
endmodule

// File: tb/tb_leaf_router_port_gen.sv
// Directed bench for leaf_router_port_gen (default parameters).
// Single-flit routing vectors are table driven; reset, round-robin,
// backpressure and arb_enable behaviour use hand-written sequences.
module tb_leaf_router_port_gen;
    localparam int DW = 16;
    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           arb_enable;
    logic [DW-1:0]  gpu_in_data;
    logic           gpu_in_valid;
    logic           gpu_in_ready;
    logic [DW-1:0]  gpu_out_data;
    logic           gpu_out_valid;
    logic           gpu_out_ready;
    logic [NS*DW-1:0] spine_in_data;
    logic [NS-1:0]  spine_in_valid;
    logic [NS-1:0]  spine_in_ready;
    logic [NS*DW-1:0] spine_out_data;
    logic [NS-1:0]  spine_out_valid;
    logic [NS-1:0]  spine_out_ready;
    logic [2:0]     current_grant;
    logic           crossbar_busy;

    always #5 clk = ~clk;

    leaf_router_port_gen dut (
        .clk             (clk),
        .reset           (reset),
        .arb_enable      (arb_enable),
        .gpu_in_data     (gpu_in_data),
        .gpu_in_valid    (gpu_in_valid),
        .gpu_in_ready    (gpu_in_ready),
        .gpu_out_data    (gpu_out_data),
        .gpu_out_valid   (gpu_out_valid),
        .gpu_out_ready   (gpu_out_ready),
        .spine_in_data   (spine_in_data),
        .spine_in_valid  (spine_in_valid),
        .spine_in_ready  (spine_in_ready),
        .spine_out_data  (spine_out_data),
        .spine_out_valid (spine_out_valid),
        .spine_out_ready (spine_out_ready),
        .current_grant   (current_grant),
        .crossbar_busy   (crossbar_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // port 0..3 = spine, 4 = loopback
    typedef struct {
        logic [15:0] flit;
        int          port;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        logic acc;
        logic [3:0] exp_vld;

        vecs[0] = '{16'h2C55, 3};
        vecs[1] = '{16'h1455, 4};
        vecs[2] = '{16'h2055, 0};
        vecs[3] = '{16'h2455, 1};
        vecs[4] = '{16'h0855, 2};
        vecs[5] = '{16'h3C00, 3};
        vecs[6] = '{16'h1C00, 4};

        reset           = 1'b1;
        arb_enable      = 1'b1;
        gpu_in_data     = 16'h2C55;
        gpu_in_valid    = 1'b1;
        gpu_out_ready   = 1'b1;
        spine_in_data   = '0;
        spine_in_valid  = '0;
        spine_out_ready = '1;

        // ---- reset held with gpu_in_valid high ----
        step();
        step();
        check("rst_spine_vld", 64'(spine_out_valid), 64'h0);
        check("rst_gpu_vld",   64'(gpu_out_valid),   64'h0);
        check("rst_in_rdy",    64'(gpu_in_ready),    64'h1);
        check("rst_grant",     64'(current_grant),   64'h0);
        check("rst_busy",      64'(crossbar_busy),   64'h0);
        check("rst_sp_rdy",    64'(spine_in_ready),  64'hF);

        // ---- load in-flight traffic, then reset mid-cycle ----
        reset           = 1'b0;
        spine_out_ready = 4'b0000;
        gpu_in_data     = 16'h2400;
        step();
        step();
        step();
        gpu_in_valid = 1'b0;
        step();
        step();
        check("load_spine_vld", 64'(spine_out_valid), 64'h2);
        check("load_busy",      64'(crossbar_busy),   64'h1);
        #2;
        reset        = 1'b1;
        gpu_in_data  = 16'h2C55;
        gpu_in_valid = 1'b1;
        #1;
        check("midrst_spine_vld", 64'(spine_out_valid), 64'h0);
        check("midrst_in_rdy",    64'(gpu_in_ready),    64'h1);
        check("midrst_busy",      64'(crossbar_busy),   64'h0);
        step();
        reset           = 1'b0;
        spine_out_ready = 4'hF;
        check("post_rst_in_rdy", 64'(gpu_in_ready), 64'h1);
        step();                                   // edge k: flit accepted
        gpu_in_valid = 1'b0;
        check("post_rst_k0", 64'(spine_out_valid), 64'h0);
        step();
        check("post_rst_k1", 64'(spine_out_valid), 64'h0);
        step();
        check("post_rst_k2_vld",  64'(spine_out_valid),       64'h8);
        check("post_rst_k2_data", 64'(spine_out_data[63:48]), 64'h2C55);
        step();
        step();

        // ---- table: single flits, GPU -> spine or loopback ----
        for (int i = 0; i < 7; i++) begin
            exp_vld      = (vecs[i].port < NS) ? 4'(1 << vecs[i].port) : 4'b0000;
            gpu_in_data  = vecs[i].flit;
            gpu_in_valid = 1'b1;
            step();
            gpu_in_valid = 1'b0;
            step();
            check($sformatf("vec%0d_k1_vld", i), 64'(spine_out_valid), 64'h0);
            step();
            check($sformatf("vec%0d_k2_vld", i),     64'(spine_out_valid), 64'(exp_vld));
            check($sformatf("vec%0d_k2_gpu_vld", i), 64'(gpu_out_valid),   64'h0);
            if (vecs[i].port < NS) begin
                check($sformatf("vec%0d_data", i),
                      64'(spine_out_data[vecs[i].port*DW +: DW]), 64'(vecs[i].flit));
            end else begin
                step();
                check($sformatf("vec%0d_lb_vld", i),   64'(gpu_out_valid), 64'h1);
                check($sformatf("vec%0d_lb_data", i),  64'(gpu_out_data),  64'(vecs[i].flit));
                check($sformatf("vec%0d_lb_grant", i), 64'(current_grant), 64'h4);
            end
            step();
            step();
            step();
        end

        // ---- round-robin across four spines ----
        spine_in_data  = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
        spine_in_valid = 4'hF;
        step();
        spine_in_valid = 4'h0;
        step();
        check("rr_k1_vld", 64'(gpu_out_valid), 64'h0);
        for (int j = 0; j < NS; j++) begin
            step();
            check($sformatf("rr%0d_vld", j),   64'(gpu_out_valid), 64'h1);
            check($sformatf("rr%0d_data", j),  64'(gpu_out_data),  64'(16'h0A00 + j));
            check($sformatf("rr%0d_grant", j), 64'(current_grant), 64'(j));
        end
        step();
        check("rr_done_vld", 64'(gpu_out_valid), 64'h0);

        // ---- backpressure on spine 1 ----
        spine_out_ready = 4'b1101;
        gpu_in_valid    = 1'b1;
        for (int n = 0; n < 5; n++) begin
            gpu_in_data = 16'(16'h2400 + n);
            check($sformatf("bp_rdy%0d", n), 64'(gpu_in_ready), 64'h1);
            step();
        end
        gpu_in_data = 16'h2405;
        step();
        step();
        check("bp_full_rdy",   64'(gpu_in_ready),          64'h0);
        check("bp_spine_vld",  64'(spine_out_valid),       64'h2);
        check("bp_spine_data", 64'(spine_out_data[31:16]), 64'h2400);
        spine_out_ready = 4'hF;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (spine_out_valid[1]) begin
                check($sformatf("bp_drain%0d", got), 64'(spine_out_data[31:16]), 64'(16'h2400 + got));
                got++;
            end
            acc = gpu_in_valid && gpu_in_ready;
            step();
            if (acc) gpu_in_valid = 1'b0;
        end
        gpu_in_valid = 1'b0;
        check("bp_drain_count", 64'(got), 64'd6);

        // ---- arb_enable=0 holds flits in spine 2 FIFO ----
        step();
        step();
        arb_enable    = 1'b0;
        spine_in_data = '0;
        for (int n = 0; n < 4; n++) begin
            spine_in_data[32 +: 16] = 16'(16'h0B20 + n);
            check($sformatf("arb_sp_rdy%0d", n), 64'(spine_in_ready[2]), 64'h1);
            spine_in_valid = 4'b0100;
            step();
        end
        spine_in_valid = 4'h0;
        step();
        step();
        check("arb_full_rdy", 64'(spine_in_ready[2]), 64'h0);
        check("arb_off_vld",  64'(gpu_out_valid),     64'h0);
        check("arb_off_busy", 64'(crossbar_busy),     64'h1);
        arb_enable = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (gpu_out_valid) begin
                check($sformatf("arb_data%0d", got),  64'(gpu_out_data),  64'(16'h0B20 + got));
                check($sformatf("arb_grant%0d", got), 64'(current_grant), 64'h2);
                got++;
            end
            step();
        end
        check("arb_count", 64'(got), 64'd4);

        // ---- a pending gpu_out flit survives arb_enable=0 ----
        gpu_out_ready          = 1'b0;
        spine_in_data[15:0]    = 16'h0C00;
        spine_in_valid         = 4'b0001;
        step();
        spine_in_valid = 4'h0;
        step();
        step();
        check("hold_vld0",  64'(gpu_out_valid), 64'h1);
        check("hold_data0", 64'(gpu_out_data),  64'h0C00);
        arb_enable = 1'b0;
        step();
        step();
        check("hold_vld1",  64'(gpu_out_valid), 64'h1);
        check("hold_data1", 64'(gpu_out_data),  64'h0C00);
        gpu_out_ready = 1'b1;
        step();
        check("hold_release", 64'(gpu_out_valid), 64'h0);
        arb_enable = 1'b1;
        step();
        step();
        check("final_busy", 64'(crossbar_busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
